// File: rtl/glb_pkg.sv
// Shared constants and types for the global-buffer arbiter slice.
package glb_pkg;

    localparam int GLB_P_WEIGHT = 0;
    localparam int GLB_P_IFMAP  = 1;
    localparam int GLB_P_IPSUM  = 2;
    localparam int GLB_P_BIAS   = 3;
    localparam int GLB_P_OPSUM  = 4;

    localparam int GLB_WORD_AW  = 14;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority finder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter  int NUM_PORT = 5,
    localparam int IW       = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic [NUM_PORT-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic [NUM_PORT-1:0] gnt,
    output logic [IW-1:0]       idx,
    output logic                found
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_PORT)) begin
                sum = sum - (IW+1)'(NUM_PORT);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/glb_arbiter.sv
// Round-robin GLB SRAM arbiter with burst lock and tagged 1-cycle read return.
// Optional performance counters are compiled in with `define GLB_ARB_PERF_EN.
module glb_arbiter
    import glb_pkg::*;
#(
    parameter  int NUM_PORT = 5,
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    localparam int IW       = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORT-1:0]              req_i,
    input  logic [NUM_PORT-1:0]              we_i,
    input  logic [NUM_PORT-1:0]              lock_i,
    input  logic [NUM_PORT-1:0][ADDR_W-1:0]  addr_i,
    input  logic [NUM_PORT-1:0][3:0]         wstrb_i,
    input  logic [NUM_PORT-1:0][DATA_W-1:0]  wdata_i,
    output logic [NUM_PORT-1:0]              gnt_o,
    output logic [NUM_PORT-1:0]              rvalid_o,
    output logic [DATA_W-1:0]                rdata_o,
    output logic [3:0]                       sram_web_o,
    output logic [GLB_WORD_AW-1:0]           sram_addr_o,
    output logic [DATA_W-1:0]                sram_wdata_o,
    input  logic [DATA_W-1:0]                sram_rdata_i
`ifdef GLB_ARB_PERF_EN
    ,
    input  logic                             perf_clr_i,
    output logic [NUM_PORT-1:0][31:0]        perf_gnt_cnt_o,
    output logic [31:0]                      perf_wait_cnt_o
`endif
);

    arb_state_e            state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         owner_q;
    logic                  pend_v;
    logic [IW-1:0]         pend_id;
    logic [GLB_WORD_AW-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic [NUM_PORT-1:0]   pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_found;

    logic [NUM_PORT-1:0]   gnt;
    logic [IW-1:0]         win;
    logic                  beat;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(NUM_PORT-1)) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(
        .NUM_PORT (NUM_PORT)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant decode: zero-cycle, forced off while reset is held.
    always_comb begin
        gnt  = '0;
        win  = '0;
        beat = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                gnt  = pick_gnt;
                win  = pick_idx;
                beat = pick_found;
            end else if (req_i[owner_q]) begin
                gnt[owner_q] = 1'b1;
                win          = owner_q;
                beat         = 1'b1;
            end
        end
    end

    assign gnt_o        = gnt;
    assign sram_addr_o  = beat ? addr_i[win][2 +: GLB_WORD_AW] : addr_q;
    assign sram_wdata_o = beat ? wdata_i[win] : wdata_q;
    assign sram_web_o   = (beat && we_i[win]) ? ~wstrb_i[win] : 4'hF;

    // Read return stage: SRAM data lands one cycle after the read beat.
    assign rvalid_o = pend_v ? (NUM_PORT'(1) << pend_id) : '0;
    assign rdata_o  = pend_v ? sram_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            pend_v   <= 1'b0;
            pend_id  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            pend_v <= beat && !we_i[win];
            if (beat) begin
                pend_id <= win;
                addr_q  <= sram_addr_o;
                wdata_q <= sram_wdata_o;
            end
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        if (lock_i[win]) begin
                            owner_q <= win;
                            state_q <= LOCKED;
                        end else begin
                            rr_ptr_q <= next_ptr(win);
                        end
                    end
                end
                LOCKED: begin
                    if (beat && !lock_i[win]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr(owner_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GLB_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [NUM_PORT-1:0][31:0] gnt_cnt_q;
    logic [31:0]               wait_cnt_q;

    // Clear wins over increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else if (perf_clr_i) begin
            gnt_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORT; p++) begin
                if (gnt[p]) begin
                    gnt_cnt_q[p] <= sat_inc(gnt_cnt_q[p]);
                end
            end
            if (|(req_i & ~gnt)) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
            end
        end
    end

    assign perf_gnt_cnt_o  = gnt_cnt_q;
    assign perf_wait_cnt_o = wait_cnt_q;
`endif

endmodule

// File: tb/tb_glb_arbiter.sv
// Directed table + hand sequences for glb_arbiter against a behavioural byte-write SRAM.
module tb_glb_arbiter;

    logic                 clk;
    logic                 rst_n;
    logic [4:0]           req, we, lock;
    logic [4:0][31:0]     addr;
    logic [4:0][3:0]      wstrb;
    logic [4:0][31:0]     wdata;
    logic [4:0]           gnt, rvalid;
    logic [31:0]          rdata;
    logic [3:0]           sram_web;
    logic [13:0]          sram_addr;
    logic [31:0]          sram_wdata;
    logic [31:0]          sram_rdata;

    logic                 pre_we;
    logic [13:0]          pre_a;
    logic [31:0]          pre_d;
    logic [31:0]          mem [0:16383];

    int total = 0;
    int bad   = 0;

    glb_arbiter #(
        .NUM_PORT (5),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .lock_i       (lock),
        .addr_i       (addr),
        .wstrb_i      (wstrb),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .sram_web_o   (sram_web),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: registered read of the old word, byte writes where web is low.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else begin
            sram_rdata <= mem[sram_addr];
            for (int b = 0; b < 4; b++) begin
                if (!sram_web[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [4:0]  req;
        logic [4:0]  we;
        logic [4:0]  lock;
        logic [4:0]  gnt;
        logic [3:0]  web;
        logic [13:0] addr;
        logic [4:0]  rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [4:0] eg, input logic [3:0] ew);
        @(negedge clk);
        chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
        chk({nm, "_web"}, 32'(sram_web), 32'(ew));
        next_cycle();
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        req    = '0;
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        req  = '0;
        lock = '0;
        we   = '0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic default_ports();
        for (int p = 0; p < 5; p++) begin
            addr[p]  = 32'(p * 32'h40);
            wdata[p] = 32'h1000_0000 + 32'(p);
            wstrb[p] = 4'hF;
        end
    endtask

    initial begin
        // port p sits at word p*0x10 holding 0xC0DE000p
        tbl[0] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 4'hF, 14'h10, 5'b00000, 32'h0};
        tbl[1] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'hF, 14'h10, 5'b00010, 32'hC0DE_0001};
        tbl[2] = '{5'b11111, 5'b00000, 5'b00000, 5'b00100, 4'hF, 14'h20, 5'b00000, 32'h0};
        tbl[3] = '{5'b11111, 5'b00000, 5'b00000, 5'b01000, 4'hF, 14'h30, 5'b00100, 32'hC0DE_0002};
        tbl[4] = '{5'b11111, 5'b00000, 5'b00000, 5'b10000, 4'hF, 14'h40, 5'b01000, 32'hC0DE_0003};
        tbl[5] = '{5'b11111, 5'b00000, 5'b00000, 5'b00001, 4'hF, 14'h00, 5'b10000, 32'hC0DE_0004};
        tbl[6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'hF, 14'h00, 5'b00001, 32'hC0DE_0000};
        tbl[7] = '{5'b10000, 5'b10000, 5'b00000, 5'b10000, 4'h0, 14'h40, 5'b00000, 32'h0};
        tbl[8] = '{5'b10000, 5'b00000, 5'b00000, 5'b10000, 4'hF, 14'h40, 5'b00000, 32'h0};
        tbl[9] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'hF, 14'h40, 5'b10000, 32'h1000_0004};

        rst_n  = 1'b1;
        req    = '0;
        we     = '0;
        lock   = '0;
        pre_we = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
        default_ports();
        #2 rst_n = 1'b0;

        for (int p = 0; p < 5; p++) preload(14'(p * 16), 32'hC0DE_0000 + 32'(p));

        // reset values, with every port requesting
        req = 5'b11111;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_web", 32'(sram_web), 32'hF);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        next_cycle();
        req = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req  = tbl[i].req;
            we   = tbl[i].we;
            lock = tbl[i].lock;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_web", i), 32'(sram_web), 32'(tbl[i].web));
            chk($sformatf("tbl%0d_addr", i), 32'(sram_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rvalid));
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdata);
            next_cycle();
        end
        req = '0;
        we  = '0;

        // all five requesting from reset: 0,1,2,3,4,0
        do_reset();
        req = 5'b11111;
        for (int i = 0; i < 6; i++) step($sformatf("rr%0d", i), 5'(1 << (i % 5)), 4'hF);

        // port 0 burst of 4 beats holds off port 4
        do_reset();
        req  = 5'b10001;
        lock = 5'b00001;
        step("lk0", 5'b00001, 4'hF);
        step("lk1", 5'b00001, 4'hF);
        step("lk2", 5'b00001, 4'hF);
        lock = 5'b00000;
        step("lk3", 5'b00001, 4'hF);
        step("lk4", 5'b10000, 4'hF);
        step("lk5", 5'b00001, 4'hF);
        req = '0;

        // partial write then read-back of the same word
        preload(14'h40, 32'hA5A5_5A5A);
        addr[4]  = 32'h100;
        wdata[4] = 32'hDEAD_BEEF;
        wstrb[4] = 4'b0011;
        req = 5'b10000;
        we  = 5'b10000;
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'h10);
        chk("wr_web", 32'(sram_web), 32'hC);
        chk("wr_addr", 32'(sram_addr), 32'h40);
        chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
        next_cycle();
        addr[2] = 32'h100;
        req = 5'b00100;
        we  = 5'b00000;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h04);
        chk("rd_web", 32'(sram_web), 32'hF);
        chk("rd_addr", 32'(sram_addr), 32'h40);
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'h04);
        chk("rd_rdata", rdata, 32'hA5A5_BEEF);
        next_cycle();
        default_ports();

        // port 2 owns the lock but idles; port 3 must wait
        req  = 5'b00100;
        lock = 5'b00100;
        step("own", 5'b00100, 4'hF);
        req  = 5'b01000;
        lock = 5'b00000;
        step("idle0", 5'b00000, 4'hF);
        step("idle1", 5'b00000, 4'hF);
        req = 5'b01100;
        step("rel", 5'b00100, 4'hF);
        req = 5'b01000;
        step("after", 5'b01000, 4'hF);
        req = '0;

        // reset right after a read beat drops the pending return
        req = 5'b00010;
        step("prerst", 5'b00010, 4'hF);
        req   = 5'b11111;
        rst_n = 1'b0;
        #1;
        chk("mrst_rvalid", 32'(rvalid), 32'h0);
        chk("mrst_rdata", rdata, 32'h0);
        step("mrst", 5'b00000, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rvalid", 32'(rvalid), 32'h0);
        chk("post_gnt", 32'(gnt), 32'h01);
        next_cycle();
        step("post1", 5'b00010, 4'hF);
        req = '0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glb_arbiter.md
# glb_arbiter

Shares the single-port 64 KB global buffer (GLB) SRAM between the token engine's streams: weight, ifmap, ipsum and bias reads, plus opsum write-back. It uses a round-robin req/gnt handshake with an optional burst lock. It drives the SRAM macro's WEB/addr/write_data pins directly. It returns read data one cycle after grant, tagged with the owning port.

## Interface
- NUM_PORT, 5, number of requesters; port 0 = weight, 1 = ifmap, 2 = ipsum, 3 = bias, 4 = opsum.
- ADDR_W, 32, requester byte-address width.
- DATA_W, 32, data word width.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORT  per-port access request.
- we_i  in  NUM_PORT  1 = write, 0 = read.
- lock_i  in  NUM_PORT  keep ownership after this beat.
- addr_i  in  NUM_PORT x ADDR_W  byte address; only [15:2] is used.
- wstrb_i  in  NUM_PORT x 4  active-high byte enables for writes.
- wdata_i  in  NUM_PORT x DATA_W  write data.
- gnt_o  out  NUM_PORT  one-hot grant, combinational.
- rvalid_o  out  NUM_PORT  one-hot read-data-valid.
- rdata_o  out  DATA_W  read data, shared by all ports.
- sram_web_o  out  4  active-low byte write enable to the SRAM.
- sram_addr_o  out  14  word address to the SRAM.
- sram_wdata_o  out  DATA_W  write data to the SRAM.
- sram_rdata_i  in  DATA_W  SRAM read data, valid one cycle after the address is presented.

## Operation
- A beat completes in any cycle where req_i[p] and gnt_o[p] are both high.
- A requester holds addr/we/wstrb/wdata/lock stable until it is granted.
- At most one gnt bit is high per cycle.
- A grant is issued only when the matching req is high.
- States: IDLE and LOCKED.
- IDLE:
  - Search req_i from rr_ptr upward, wrapping modulo NUM_PORT; the first set port wins.
  - On a beat with lock_i = 0: rr_ptr <= winner+1, wrapping from NUM_PORT-1 to 0.
  - On a beat with lock_i = 1: record owner <= winner and go to LOCKED; rr_ptr does not move.
- LOCKED:
  - Only the owner can be granted; other requests wait.
  - Owner req low: idle cycle, no SRAM access, state held.
  - Owner beat with lock_i = 1: stay in LOCKED.
  - Owner beat with lock_i = 0: go to IDLE, rr_ptr <= owner+1.
- SRAM drive:
  - sram_addr_o = addr_i[winner][15:2].
  - sram_wdata_o = wdata_i[winner].
  - sram_web_o = ~wstrb_i[winner] for a write beat; 4'hF otherwise.
  - With no beat, sram_addr_o and sram_wdata_o hold their previous values (registered copies), and sram_web_o = 4'hF.
- Read return:
  - A read beat sets pend_id and pend_v.
  - The next cycle: rvalid_o[pend_id] = 1 and rdata_o = sram_rdata_i.
  - Writes produce no rvalid.
- Reads and writes may alternate back-to-back with no bubble.

## Timing
- gnt_o and the SRAM pins are combinational from req_i and state, giving zero-cycle grant.
- Read latency is 1 cycle from beat to rvalid.
- Sustained throughput is 1 beat per cycle.
- Reset values:
  - state = IDLE, rr_ptr = 0, pend_v = 0.
  - rvalid_o = 0, rdata_o = 0.
  - sram_web_o = 4'hF, sram_addr_o = 0, sram_wdata_o = 0.
  - gnt_o = 0 while rst_n is low.
- Reset mid-burst: the lock is dropped and a pending rvalid is discarded.
- A write beat immediately followed by a read of the same address returns the new data, as guaranteed by the SRAM's write-then-read ordering.

## Configuration
- GLB_ARB_PERF_EN defined adds three ports:
  - perf_clr_i  in  1  clears all counters.
  - perf_gnt_cnt_o  out  NUM_PORT x 32  beats per port, saturating at 32'hFFFF_FFFF.
  - perf_wait_cnt_o  out  32  cycles with any req high but not granted, saturating.
- perf_clr_i takes priority over increment in the same cycle.
- Undefined: none of these ports or counters exist, and arbitration behaviour is identical.

## Structure
- glb_pkg holds:
  - port index constants GLB_P_WEIGHT .. GLB_P_OPSUM;
  - the arb_state_e enum (IDLE, LOCKED);
  - GLB_WORD_AW = 14.
- Sub-module rr_pick: combinational round-robin priority finder taking req vector and rr_ptr, returning a one-hot grant and its index.

## Test plan
- Reset, then req_i = 5'b00010 (ifmap read at addr 0x40) -> gnt_o = 5'b00010 and sram_addr_o = 0x10 the same cycle; rvalid_o[1] = 1 the next cycle with rdata_o = mem[0x10].
- All five requesting continuously from reset -> grant order 0,1,2,3,4,0; each port gets exactly one beat per 5 cycles.
- Port 0 holds lock_i = 1 for 3 beats, then 0, while port 4 requests -> port 4 is blocked for 4 beats and granted on the next cycle; rr_ptr = 1 afterwards.
- Port 4 writes 0xDEADBEEF with wstrb = 4'b0011 to 0x100, then port 2 reads 0x100 next cycle -> sram_web_o = 4'b1100; rdata_o = 0xXXXXBEEF, with upper bytes unchanged from the preloaded value.
- Port 2 locked with req low for 2 cycles while port 3 requests -> no gnt and sram_web_o = 4'hF for both cycles.
- rst_n pulsed low one cycle after a read beat -> rvalid_o stays 0; state = IDLE, rr_ptr = 0.
